// File: rtl/iseq_pkg.sv
// Shared constants and FSM state encoding for the instruction-sequence loader.
package iseq_pkg;

  localparam logic [2:0]  OPC_END   = 3'b111;
  // Zero-cycle no-op used to fill slot 1 when a sequence has an odd count.
  localparam logic [31:0] PAD_INSTR = 32'h0000_0000;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PAD,
    KICK,
    WAIT_HI,
    WAIT_LO
  } iseq_state_e;

endpackage

// File: rtl/iseq_loader.sv
// Splits a host instruction stream across two slot FIFOs, pads odd-length
// sequences, then kicks the dispatcher and waits for it to finish.
module iseq_loader
  import iseq_pkg::*;
#(
  parameter int MAX_ISEQ_LEN = 1024,
  parameter int LEN_WIDTH    = 11
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [31:0]          in_data,
  output logic                 in_ready,
  output logic                 instr0_fifo_wr,
  output logic [31:0]          instr0_fifo_wdata,
  input  logic                 instr0_fifo_full,
  output logic                 instr1_fifo_wr,
  output logic [31:0]          instr1_fifo_wdata,
  input  logic                 instr1_fifo_full,
  output logic                 process_iseq,
  input  logic                 dispatcher_busy,
  output logic                 loader_busy,
  output logic [LEN_WIDTH-1:0] iseq_len,
  output logic                 err_overflow,
  input  logic                 err_clr,
  output iseq_state_e          state_dbg
);

  localparam logic [LEN_WIDTH-1:0] MAX_CNT = LEN_WIDTH'(MAX_ISEQ_LEN);

  // Handshake: a word transfers on a cycle where in_valid && in_ready;
  // in_data must stay stable while in_valid is high and in_ready is low.

  iseq_state_e          state, state_nxt;
  logic                 slot, slot_nxt;
  logic [LEN_WIDTH-1:0] count, count_nxt;
  logic [LEN_WIDTH-1:0] len_nxt;
  logic                 err_nxt;

  logic is_end, target_full, accept, at_max, wr_word, pad_wr;

  assign state_dbg = state;

  always_comb begin
    is_end      = (in_data[31:29] == OPC_END);
    target_full = slot ? instr1_fifo_full : instr0_fifo_full;
    // rst_n gates acceptance so nothing leaks out while reset is held.
    in_ready    = rst_n && ((state == IDLE) || (state == LOAD)) && !target_full;
    accept      = in_valid && in_ready;
    at_max      = (count == MAX_CNT);
    wr_word     = accept && !is_end && !at_max;
    pad_wr      = (state == PAD) && !instr1_fifo_full;

    instr0_fifo_wr    = wr_word && !slot;
    instr1_fifo_wr    = (wr_word && slot) || pad_wr;
    instr0_fifo_wdata = instr0_fifo_wr ? in_data : '0;
    instr1_fifo_wdata = pad_wr ? PAD_INSTR : (instr1_fifo_wr ? in_data : '0);

    process_iseq = (state == KICK);
    loader_busy  = (state != IDLE);
  end

  always_comb begin
    state_nxt = state;
    slot_nxt  = slot;
    count_nxt = count;
    len_nxt   = iseq_len;
    err_nxt   = err_overflow;

    // Set takes priority over a simultaneous clear.
    if (accept && !is_end && at_max)
      err_nxt = 1'b1;
    else if (err_clr)
      err_nxt = 1'b0;

    case (state)
      IDLE, LOAD: begin
        if (accept) begin
          if (is_end) begin
            if (count == '0)
              state_nxt = IDLE;
            else if (slot)
              state_nxt = PAD;
            else
              state_nxt = KICK;
          end else begin
            state_nxt = LOAD;
            if (!at_max) begin
              slot_nxt  = ~slot;
              count_nxt = count + LEN_WIDTH'(1);
            end
          end
        end
      end
      PAD: begin
        if (!instr1_fifo_full) begin
          count_nxt = count + LEN_WIDTH'(1);
          slot_nxt  = 1'b0;
          state_nxt = KICK;
        end
      end
      KICK: begin
        len_nxt   = count;
        state_nxt = WAIT_HI;
      end
      WAIT_HI: begin
        if (dispatcher_busy) state_nxt = WAIT_LO;
      end
      WAIT_LO: begin
        if (!dispatcher_busy) begin
          state_nxt = IDLE;
          count_nxt = '0;
          slot_nxt  = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      slot         <= 1'b0;
      count        <= '0;
      iseq_len     <= '0;
      err_overflow <= 1'b0;
    end else begin
      state        <= state_nxt;
      slot         <= slot_nxt;
      count        <= count_nxt;
      iseq_len     <= len_nxt;
      err_overflow <= err_nxt;
    end
  end

endmodule

// File: tb/tb_iseq_loader.sv
// Directed bench for iseq_loader built with MAX_ISEQ_LEN=4 so overflow is reachable.
module tb_iseq_loader;
  import iseq_pkg::*;

  localparam int MAX_LEN = 4;
  localparam int LW      = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [31:0]   in_data = '0;
  logic          in_ready;
  logic          instr0_fifo_wr, instr1_fifo_wr;
  logic [31:0]   instr0_fifo_wdata, instr1_fifo_wdata;
  logic          instr0_fifo_full = 1'b0;
  logic          instr1_fifo_full = 1'b0;
  logic          process_iseq;
  logic          dispatcher_busy;
  logic          loader_busy;
  logic [LW-1:0] iseq_len;
  logic          err_overflow;
  logic          err_clr = 1'b0;
  iseq_state_e   state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [31:0] END_W = 32'hE000_0055;

  // ---------------- clock / reset / dispatcher model ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [2:0] disp_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)              disp_cnt <= '0;
    else if (process_iseq)   disp_cnt <= 3'd3;
    else if (disp_cnt != 0)  disp_cnt <= disp_cnt - 3'd1;
  end
  assign dispatcher_busy = (disp_cnt != 0);

  iseq_loader #(.MAX_ISEQ_LEN(MAX_LEN), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .instr0_fifo_wr(instr0_fifo_wr), .instr0_fifo_wdata(instr0_fifo_wdata),
    .instr0_fifo_full(instr0_fifo_full),
    .instr1_fifo_wr(instr1_fifo_wr), .instr1_fifo_wdata(instr1_fifo_wdata),
    .instr1_fifo_full(instr1_fifo_full),
    .process_iseq(process_iseq), .dispatcher_busy(dispatcher_busy),
    .loader_busy(loader_busy), .iseq_len(iseq_len),
    .err_overflow(err_overflow), .err_clr(err_clr), .state_dbg(state_dbg)
  );

  // ---------------- FIFO-side monitor ----------------
  logic [31:0] got0_q[$];
  logic [31:0] got1_q[$];
  logic [31:0] exp0_q[$];
  logic [31:0] exp1_q[$];
  int pulse_cnt = 0, busy_seen = 0, both_wr_cnt = 0, pad_cyc = -1, kick_cyc = -1;

  always @(negedge clk) begin
    if (instr0_fifo_wr) got0_q.push_back(instr0_fifo_wdata);
    if (instr1_fifo_wr) begin
      got1_q.push_back(instr1_fifo_wdata);
      if (instr1_fifo_wdata == PAD_INSTR) pad_cyc = cyc;
    end
    if (process_iseq) begin
      pulse_cnt = pulse_cnt + 1;
      kick_cyc  = cyc;
    end
    if (loader_busy) busy_seen = busy_seen + 1;
    if (instr0_fifo_wr && instr1_fifo_wr) both_wr_cnt = both_wr_cnt + 1;
  end

  // ---------------- driver tasks ----------------
  // Presents one word and holds it until accepted; returns at posedge+1.
  task automatic send(input logic [31:0] d);
    int t;
    in_valid = 1'b1;
    in_data  = d;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      t++;
      @(negedge clk);
    end
    if (!in_ready) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout data=%h in_ready=%b required=1", d, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    @(negedge clk);
    while (state_dbg != IDLE && t < 60) begin
      t++;
      @(negedge clk);
    end
    if (state_dbg != IDLE) begin
      n_checks++; n_fail++;
      $display("FAIL %s idle_timeout state=%0d required=%0d", name, state_dbg, IDLE);
    end
    @(posedge clk); #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    in_valid = 1'b1;
    in_data  = 32'h0A00_0001;
    #12;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready got=%b req=0", in_ready); end
    n_checks++; if (instr0_fifo_wr !== 1'b0 || instr1_fifo_wr !== 1'b0) begin n_fail++; $display("FAIL rst_wr got=%b%b req=00", instr0_fifo_wr, instr1_fifo_wr); end
    n_checks++; if (instr0_fifo_wdata !== 32'h0 || instr1_fifo_wdata !== 32'h0) begin n_fail++; $display("FAIL rst_wdata got=%h/%h req=0", instr0_fifo_wdata, instr1_fifo_wdata); end
    n_checks++; if (process_iseq !== 1'b0 || loader_busy !== 1'b0) begin n_fail++; $display("FAIL rst_pulse_busy got=%b%b req=00", process_iseq, loader_busy); end
    n_checks++; if (iseq_len !== 3'd0 || err_overflow !== 1'b0) begin n_fail++; $display("FAIL rst_len_err got=%0d/%b req=0/0", iseq_len, err_overflow); end
    n_checks++; if (state_dbg !== IDLE) begin n_fail++; $display("FAIL rst_state got=%0d req=%0d", state_dbg, IDLE); end
    in_valid = 1'b0;
    in_data  = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1 || state_dbg !== IDLE) begin n_fail++; $display("FAIL rst_release got ready=%b state=%0d req 1/%0d", in_ready, state_dbg, IDLE); end
    @(posedge clk); #1;
  endtask

  task automatic test_four_words;
    int b0, b1, p0;
    b0 = got0_q.size(); b1 = got1_q.size(); p0 = pulse_cnt;
    exp0_q = '{32'h0A00_00A1, 32'h0A00_00C3};
    exp1_q = '{32'h0A00_00B2, 32'h0A00_00D4};
    send(32'h0A00_00A1); send(32'h0A00_00B2); send(32'h0A00_00C3); send(32'h0A00_00D4);
    send(END_W);
    wait_idle("four_words");
    n_checks++;
    if (got0_q.size() - b0 !== 2 || got1_q.size() - b1 !== 2) begin
      n_fail++; $display("FAIL four_words_count got=%0d/%0d req=2/2", got0_q.size() - b0, got1_q.size() - b1);
    end else begin
      for (int i = 0; i < 2; i++) begin
        n_checks++; if (got0_q[b0+i] !== exp0_q[i]) begin n_fail++; $display("FAIL four_words_fifo0[%0d] got=%h req=%h", i, got0_q[b0+i], exp0_q[i]); end
        n_checks++; if (got1_q[b1+i] !== exp1_q[i]) begin n_fail++; $display("FAIL four_words_fifo1[%0d] got=%h req=%h", i, got1_q[b1+i], exp1_q[i]); end
      end
    end
    n_checks++; if (pulse_cnt - p0 !== 1) begin n_fail++; $display("FAIL four_words_pulses got=%0d req=1", pulse_cnt - p0); end
    n_checks++; if (iseq_len !== 3'd4) begin n_fail++; $display("FAIL four_words_len got=%0d req=4", iseq_len); end
  endtask

  task automatic test_pad;
    int b0, b1, p0;
    b0 = got0_q.size(); b1 = got1_q.size(); p0 = pulse_cnt;
    exp0_q = '{32'h0B00_00A1, 32'h0B00_00C3};
    exp1_q = '{32'h0B00_00B2, PAD_INSTR};
    send(32'h0B00_00A1); send(32'h0B00_00B2); send(32'h0B00_00C3);
    send(END_W);
    wait_idle("pad");
    n_checks++;
    if (got0_q.size() - b0 !== 2 || got1_q.size() - b1 !== 2) begin
      n_fail++; $display("FAIL pad_count got=%0d/%0d req=2/2", got0_q.size() - b0, got1_q.size() - b1);
    end else begin
      for (int i = 0; i < 2; i++) begin
        n_checks++; if (got0_q[b0+i] !== exp0_q[i]) begin n_fail++; $display("FAIL pad_fifo0[%0d] got=%h req=%h", i, got0_q[b0+i], exp0_q[i]); end
        n_checks++; if (got1_q[b1+i] !== exp1_q[i]) begin n_fail++; $display("FAIL pad_fifo1[%0d] got=%h req=%h", i, got1_q[b1+i], exp1_q[i]); end
      end
    end
    n_checks++; if (iseq_len !== 3'd4) begin n_fail++; $display("FAIL pad_len got=%0d req=4", iseq_len); end
    n_checks++; if (pulse_cnt - p0 !== 1) begin n_fail++; $display("FAIL pad_pulses got=%0d req=1", pulse_cnt - p0); end
    n_checks++; if (kick_cyc - pad_cyc !== 1) begin n_fail++; $display("FAIL pad_kick_latency got=%0d req=1", kick_cyc - pad_cyc); end
  endtask

  task automatic test_end_only;
    int b0, b1, p0, bs0;
    b0 = got0_q.size(); b1 = got1_q.size(); p0 = pulse_cnt;
    send(END_W);
    bs0 = busy_seen;
    repeat (6) @(posedge clk);
    #1;
    n_checks++; if (got0_q.size() != b0 || got1_q.size() != b1) begin n_fail++; $display("FAIL end_only_writes got=%0d/%0d req=0/0", got0_q.size() - b0, got1_q.size() - b1); end
    n_checks++; if (pulse_cnt - p0 !== 0) begin n_fail++; $display("FAIL end_only_pulses got=%0d req=0", pulse_cnt - p0); end
    n_checks++; if (busy_seen - bs0 !== 0) begin n_fail++; $display("FAIL end_only_busy got=%0d req=0", busy_seen - bs0); end
    n_checks++; if (state_dbg !== IDLE) begin n_fail++; $display("FAIL end_only_state got=%0d req=%0d", state_dbg, IDLE); end
  endtask

  task automatic test_full_stall;
    int b0, b1;
    b0 = got0_q.size(); b1 = got1_q.size();
    send(32'h0C00_00A1);
    instr1_fifo_full = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'h0C00_00B2;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready[%0d] got=%b req=0", i, in_ready); end
      @(posedge clk); #1;
    end
    instr1_fifo_full = 1'b0;
    send(32'h0C00_00B2);
    send(END_W);
    wait_idle("stall");
    n_checks++;
    if (got1_q.size() - b1 !== 1) begin
      n_fail++; $display("FAIL stall_fifo1_count got=%0d req=1", got1_q.size() - b1);
    end else begin
      n_checks++; if (got1_q[b1] !== 32'h0C00_00B2) begin n_fail++; $display("FAIL stall_fifo1_data got=%h req=0c0000b2", got1_q[b1]); end
    end
    n_checks++; if (got0_q.size() - b0 !== 1) begin n_fail++; $display("FAIL stall_fifo0_count got=%0d req=1", got0_q.size() - b0); end
    n_checks++; if (iseq_len !== 3'd2) begin n_fail++; $display("FAIL stall_len got=%0d req=2", iseq_len); end
  endtask

  task automatic test_overflow;
    int b0, b1;
    b0 = got0_q.size(); b1 = got1_q.size();
    exp0_q = '{32'h0D00_0000, 32'h0D00_0002};
    exp1_q = '{32'h0D00_0001, 32'h0D00_0003};
    for (int i = 0; i < 6; i++) send(32'h0D00_0000 + i);
    send(END_W);
    wait_idle("overflow");
    n_checks++;
    if (got0_q.size() - b0 !== 2 || got1_q.size() - b1 !== 2) begin
      n_fail++; $display("FAIL ovf_count got=%0d/%0d req=2/2", got0_q.size() - b0, got1_q.size() - b1);
    end else begin
      for (int i = 0; i < 2; i++) begin
        n_checks++; if (got0_q[b0+i] !== exp0_q[i]) begin n_fail++; $display("FAIL ovf_fifo0[%0d] got=%h req=%h", i, got0_q[b0+i], exp0_q[i]); end
        n_checks++; if (got1_q[b1+i] !== exp1_q[i]) begin n_fail++; $display("FAIL ovf_fifo1[%0d] got=%h req=%h", i, got1_q[b1+i], exp1_q[i]); end
      end
    end
    n_checks++; if (err_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_err_set got=%b req=1", err_overflow); end
    n_checks++; if (iseq_len !== 3'd4) begin n_fail++; $display("FAIL ovf_len got=%0d req=4", iseq_len); end
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    n_checks++; if (err_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_err_clr got=%b req=0", err_overflow); end
  endtask

  task automatic test_reset_mid_sequence;
    int b0, b1, p0;
    b0 = got0_q.size(); b1 = got1_q.size(); p0 = pulse_cnt;
    send(32'h0E00_00A1); send(32'h0E00_00B2);
    in_valid = 1'b1;
    in_data  = 32'h0E00_00FF;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (in_ready !== 1'b0 || instr0_fifo_wr !== 1'b0 || instr1_fifo_wr !== 1'b0) begin n_fail++; $display("FAIL midrst_hs got ready=%b wr=%b%b req=0/00", in_ready, instr0_fifo_wr, instr1_fifo_wr); end
    n_checks++; if (instr0_fifo_wdata !== 32'h0 || loader_busy !== 1'b0 || process_iseq !== 1'b0) begin n_fail++; $display("FAIL midrst_out got wdata0=%h busy=%b kick=%b req=0/0/0", instr0_fifo_wdata, loader_busy, process_iseq); end
    n_checks++; if (iseq_len !== 3'd0 || state_dbg !== IDLE) begin n_fail++; $display("FAIL midrst_len_state got=%0d/%0d req=0/%0d", iseq_len, state_dbg, IDLE); end
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = '0;
    rst_n = 1'b1;
    n_checks++; if (pulse_cnt - p0 !== 0) begin n_fail++; $display("FAIL midrst_pulse got=%0d req=0", pulse_cnt - p0); end
    exp0_q = '{32'h0E00_00A1, 32'h0E00_0011};
    exp1_q = '{32'h0E00_00B2, 32'h0E00_0022};
    send(32'h0E00_0011); send(32'h0E00_0022);
    send(END_W);
    wait_idle("midrst");
    n_checks++;
    if (got0_q.size() - b0 !== 2 || got1_q.size() - b1 !== 2) begin
      n_fail++; $display("FAIL midrst_count got=%0d/%0d req=2/2", got0_q.size() - b0, got1_q.size() - b1);
    end else begin
      for (int i = 0; i < 2; i++) begin
        n_checks++; if (got0_q[b0+i] !== exp0_q[i]) begin n_fail++; $display("FAIL midrst_fifo0[%0d] got=%h req=%h", i, got0_q[b0+i], exp0_q[i]); end
        n_checks++; if (got1_q[b1+i] !== exp1_q[i]) begin n_fail++; $display("FAIL midrst_fifo1[%0d] got=%h req=%h", i, got1_q[b1+i], exp1_q[i]); end
      end
    end
    n_checks++; if (pulse_cnt - p0 !== 1) begin n_fail++; $display("FAIL midrst_new_pulse got=%0d req=1", pulse_cnt - p0); end
    n_checks++; if (iseq_len !== 3'd2) begin n_fail++; $display("FAIL midrst_len got=%0d req=2", iseq_len); end
  endtask

  // ---------------- sequence + final report ----------------
  initial begin
    test_reset;
    test_four_words;
    test_pad;
    test_end_only;
    test_full_stall;
    test_overflow;
    test_reset_mid_sequence;
    n_checks++;
    if (both_wr_cnt !== 0) begin n_fail++; $display("FAIL dual_write got=%0d req=0", both_wr_cnt); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
